// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state type for uart_param
package uart_pkg;

    localparam int PAR_NONE   = 0;
    localparam int PAR_EVEN   = 1;
    localparam int PAR_ODD    = 2;

    localparam int OVERSAMPLE = 16;
    localparam int MID_BIT    = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

endpackage

// File: rtl/uart_param_if.sv
// rtl/uart_param_if.sv - CPU-side bus of uart_param (RX FIFO read side, TX holding register write side)
interface uart_param_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
);
    logic                          rdn;
    logic [DATA_BITS-1:0]          d_out;
    logic                          r_ready;
    logic                          parity_error;
    logic                          frame_error;
    logic                          overrun;
    logic [$clog2(FIFO_DEPTH):0]   r_count;
    logic                          wrn;
    logic [DATA_BITS-1:0]          d_in;
    logic                          t_empty;

    modport master (
        output rdn, wrn, d_in,
        input  d_out, r_ready, parity_error, frame_error, overrun, r_count, t_empty
    );

    modport slave (
        input  rdn, wrn, d_in,
        output d_out, r_ready, parity_error, frame_error, overrun, r_count, t_empty
    );
endinterface

// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - synchronous show-ahead FIFO; head reads as zero while empty
module uart_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees a slot on the same edge
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/uart_param.sv
// rtl/uart_param.sv - parametrised UART on the baud x16 clock with RX FIFO and TX holding register
// Optional internal loopback path enabled by UART_PARAM_LOOPBACK_EN.
module uart_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic clk16x,
    input  logic clrn,
    input  logic rxd,
    output logic txd,
`ifdef UART_PARAM_LOOPBACK_EN
    input  logic loopback,
`endif
    uart_param_if.slave bus
);
    localparam int         CW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [3:0] TICK_MID    = 4'(MID_BIT - 1);
    localparam logic [3:0] TICK_END    = 4'(OVERSAMPLE - 1);
    localparam logic [2:0] DATA_LAST   = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST   = 3'(STOP_BITS - 1);
    localparam logic       PAR_EN      = (PARITY != PAR_NONE);
    localparam logic       PAR_ODD_BIT = (PARITY == PAR_ODD);

    uart_state_e          rx_state_q, rx_state_d, tx_state_q, tx_state_d;
    logic [3:0]           rx_tick_q, rx_tick_d, tx_tick_q, tx_tick_d;
    logic [2:0]           rx_bit_q, rx_bit_d, tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d, hold_q, hold_d;
    logic                 rx_perr_q, rx_perr_d, rx_ferr_q, rx_ferr_d;
    logic                 tx_par_q, tx_par_d, tx_line_q, tx_line_d, t_empty_q, t_empty_d;
    logic                 overrun_q, overrun_d;
    logic                 rx_meta_q, rx_sync_q, rx_prev_q, rx_in, rx_fall, rx_sample, rx_push;
    logic                 tx_bit_end, tx_load;
    logic [DATA_BITS+1:0] fifo_rdata;
    logic                 fifo_full, fifo_empty;
    logic [CW-1:0]        r_count;

`ifdef UART_PARAM_LOOPBACK_EN
    assign rx_in = loopback ? tx_line_q : rx_sync_q;
    assign txd   = loopback ? 1'b1 : tx_line_q;
`else
    assign rx_in = rx_sync_q;
    assign txd   = tx_line_q;
`endif

    assign rx_fall   = rx_prev_q & ~rx_in;
    assign rx_sample = ((rx_state_q == ST_START) && (rx_tick_q == TICK_MID)) ||
                       ((rx_state_q inside {ST_DATA, ST_PARITY, ST_STOP}) && (rx_tick_q == TICK_END));

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            ST_IDLE:   if (rx_fall) rx_state_d = ST_START;
            ST_START:  if (rx_sample) rx_state_d = rx_in ? ST_IDLE : ST_DATA;
            ST_DATA:   if (rx_sample && rx_bit_q == DATA_LAST) rx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (rx_sample) rx_state_d = ST_STOP;
            ST_STOP:   if (rx_sample && rx_bit_q == STOP_LAST) rx_state_d = ST_IDLE;
            default:   rx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rx_tick_d  = (rx_state_q == ST_IDLE || rx_sample) ? 4'd0 : rx_tick_q + 4'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_ferr_d  = rx_ferr_q;
        rx_push    = 1'b0;
        if (rx_sample) begin
            case (rx_state_q)
                ST_START: begin
                    rx_bit_d  = 3'd0;
                    rx_perr_d = 1'b0;
                    rx_ferr_d = 1'b0;
                end
                ST_DATA: begin
                    rx_shift_d = {rx_in, rx_shift_q[DATA_BITS-1:1]};
                    rx_bit_d   = (rx_bit_q == DATA_LAST) ? 3'd0 : rx_bit_q + 3'd1;
                end
                ST_PARITY: rx_perr_d = ^rx_shift_q ^ rx_in ^ PAR_ODD_BIT;
                ST_STOP: begin
                    rx_ferr_d = rx_ferr_q | ~rx_in;
                    rx_bit_d  = rx_bit_q + 3'd1;
                    rx_push   = (rx_bit_q == STOP_LAST);
                end
                default: ;
            endcase
        end
    end

    assign overrun_d = (~bus.rdn & ~fifo_empty) ? 1'b0 :
                       (rx_push & fifo_full)    ? 1'b1 : overrun_q;

    uart_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (clk16x),
        .rst_n (clrn),
        .push  (rx_push),
        .wdata ({rx_shift_q, rx_perr_q, rx_ferr_d}),
        .pop   (~bus.rdn),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (r_count)
    );

    assign bus.d_out        = fifo_rdata[DATA_BITS+1:2];
    assign bus.parity_error = fifo_rdata[1];
    assign bus.frame_error  = fifo_rdata[0];
    assign bus.r_ready      = ~fifo_empty;
    assign bus.r_count      = r_count;
    assign bus.overrun      = overrun_q;
    assign bus.t_empty      = t_empty_q;

    assign tx_bit_end = (tx_state_q != ST_IDLE) && (tx_tick_q == TICK_END);
    // Reloading at the end of the last stop bit gives back-to-back frames with no idle gap
    assign tx_load    = ~t_empty_q & ((tx_state_q == ST_IDLE) ||
                        ((tx_state_q == ST_STOP) && tx_bit_end && tx_bit_q == STOP_LAST));

    always_comb begin
        tx_state_d = tx_state_q;
        case (tx_state_q)
            ST_IDLE:   if (tx_load) tx_state_d = ST_START;
            ST_START:  if (tx_bit_end) tx_state_d = ST_DATA;
            ST_DATA:   if (tx_bit_end && tx_bit_q == DATA_LAST) tx_state_d = PAR_EN ? ST_PARITY : ST_STOP;
            ST_PARITY: if (tx_bit_end) tx_state_d = ST_STOP;
            ST_STOP:   if (tx_bit_end && tx_bit_q == STOP_LAST) tx_state_d = tx_load ? ST_START : ST_IDLE;
            default:   tx_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_tick_d  = (tx_state_q == ST_IDLE || tx_bit_end) ? 4'd0 : tx_tick_q + 4'd1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_line_d  = tx_line_q;
        hold_d     = hold_q;
        t_empty_d  = t_empty_q;
        if (!bus.wrn && t_empty_q) begin
            hold_d    = bus.d_in;
            t_empty_d = 1'b0;
        end
        if (tx_load) begin
            tx_shift_d = hold_q;
            tx_par_d   = ^hold_q ^ PAR_ODD_BIT;
            tx_line_d  = 1'b0;
            tx_bit_d   = 3'd0;
            t_empty_d  = 1'b1;
        end else if (tx_state_q == ST_IDLE) begin
            tx_line_d = 1'b1;
        end else if (tx_bit_end) begin
            case (tx_state_q)
                ST_START: begin
                    tx_line_d = tx_shift_q[0];
                    tx_bit_d  = 3'd0;
                end
                ST_DATA: begin
                    if (tx_bit_q == DATA_LAST) begin
                        tx_line_d = PAR_EN ? tx_par_q : 1'b1;
                        tx_bit_d  = 3'd0;
                    end else begin
                        tx_shift_d = tx_shift_q >> 1;
                        tx_line_d  = tx_shift_q[1];
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    tx_line_d = 1'b1;
                    tx_bit_d  = 3'd0;
                end
                ST_STOP: begin
                    tx_line_d = 1'b1;
                    tx_bit_d  = tx_bit_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk16x or negedge clrn) begin
        if (!clrn) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
            overrun_q  <= 1'b0;
            tx_state_q <= ST_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_line_q  <= 1'b1;
            hold_q     <= '0;
            t_empty_q  <= 1'b1;
        end else begin
            rx_meta_q  <= rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_in;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_perr_q  <= rx_perr_d;
            rx_ferr_q  <= rx_ferr_d;
            overrun_q  <= overrun_d;
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_line_q  <= tx_line_d;
            hold_q     <= hold_d;
            t_empty_q  <= t_empty_d;
        end
    end
endmodule

// File: tb/tb_uart_param.sv
// tb/tb_uart_param.sv - directed self-checking bench for uart_param (8N1 and 8E1 instances)
module tb_uart_param;
    logic clk16x = 1'b0;
    logic clrn   = 1'b0;
    logic rx_line = 1'b1;
    logic rx_sel  = 1'b0;
    logic rxd_n, rxd_e, txd_n, txd_e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   t0;

    uart_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_n ();
    uart_param_if #(.DATA_BITS(8), .FIFO_DEPTH(4)) bus_e ();

    uart_param #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk16x (clk16x),
        .clrn   (clrn),
        .rxd    (rxd_n),
        .txd    (txd_n),
`ifdef UART_PARAM_LOOPBACK_EN
        .loopback (1'b0),
`endif
        .bus    (bus_n)
    );

    uart_param #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
        .clk16x (clk16x),
        .clrn   (clrn),
        .rxd    (rxd_e),
        .txd    (txd_e),
`ifdef UART_PARAM_LOOPBACK_EN
        .loopback (1'b0),
`endif
        .bus    (bus_e)
    );

    always #5 clk16x = ~clk16x;
    always @(posedge clk16x) cyc <= cyc + 1;

    assign rxd_n = rx_sel ? 1'b1 : rx_line;
    assign rxd_e = rx_sel ? rx_line : 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk16x);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk16x);
            #1;
        end
    endtask

    task automatic wr_n(input logic [7:0] b);
        bus_n.d_in = b;
        bus_n.wrn  = 1'b0;
        step(1);
        bus_n.wrn  = 1'b1;
    endtask

    task automatic check_frame(input logic [7:0] data, input int start);
        logic [9:0] bits;
        bits = {1'b1, data, 1'b0};
        for (int k = 0; k < 10; k++) begin
            wait_until(start + 16*k);
            chk($sformatf("tx_%0h_bit%0d_first", data, k), txd_n, bits[k]);
            wait_until(start + 16*k + 15);
            chk($sformatf("tx_%0h_bit%0d_last", data, k), txd_n, bits[k]);
        end
    endtask

    task automatic send_rx(input logic sel, input logic [7:0] data, input logic has_par,
                           input logic pbit, input logic stopv);
        rx_sel  = sel;
        rx_line = 1'b0;
        step(16);
        for (int i = 0; i < 8; i++) begin
            rx_line = data[i];
            step(16);
        end
        if (has_par) begin
            rx_line = pbit;
            step(16);
        end
        rx_line = stopv;
        step(16);
        rx_line = 1'b1;
    endtask

    initial begin
        bus_n.rdn = 1'b1; bus_n.wrn = 1'b1; bus_n.d_in = '0;
        bus_e.rdn = 1'b1; bus_e.wrn = 1'b1; bus_e.d_in = '0;
        step(3);

        chk("rst_d_out", bus_n.d_out, 0);
        chk("rst_r_ready", bus_n.r_ready, 0);
        chk("rst_parity_error", bus_n.parity_error, 0);
        chk("rst_frame_error", bus_n.frame_error, 0);
        chk("rst_overrun", bus_n.overrun, 0);
        chk("rst_r_count", bus_n.r_count, 0);
        chk("rst_t_empty", bus_n.t_empty, 1);
        chk("rst_txd", txd_n, 1);
        chk("rst_e_txd", txd_e, 1);
        chk("rst_e_r_count", bus_e.r_count, 0);
        clrn = 1'b1;
        step(2);

        // 8N1 transmit of 0xA5
        wr_n(8'hA5);
        t0 = cyc + 1;
        chk("tx_tempty_after_write", bus_n.t_empty, 0);
        chk("tx_txd_before_start", txd_n, 1);
        check_frame(8'hA5, t0);
        wait_until(t0 + 160);
        chk("tx_idle_after_frame", txd_n, 1);
        chk("tx_tempty_after_frame", bus_n.t_empty, 1);
        step(20);

        // Back-to-back transmit, third write ignored
        wr_n(8'h11);
        t0 = cyc + 1;
        step(1);
        chk("b2b_tempty_freed", bus_n.t_empty, 1);
        bus_n.d_in = 8'h22;
        bus_n.wrn  = 1'b0;
        step(1);
        chk("b2b_second_taken", bus_n.t_empty, 0);
        bus_n.d_in = 8'h33;
        step(1);
        bus_n.wrn  = 1'b1;
        chk("b2b_third_ignored", bus_n.t_empty, 0);
        check_frame(8'h11, t0);
        check_frame(8'h22, t0 + 160);
        wait_until(t0 + 320 + 8);
        chk("b2b_no_third_frame", txd_n, 1);
        chk("b2b_tempty_end", bus_n.t_empty, 1);

        // 8E1 receive, good then bad parity
        send_rx(1'b1, 8'h3C, 1'b1, 1'b0, 1'b1);
        chk("e1_r_ready", bus_e.r_ready, 1);
        chk("e1_d_out", bus_e.d_out, 8'h3C);
        chk("e1_parity_ok", bus_e.parity_error, 0);
        chk("e1_frame_ok", bus_e.frame_error, 0);
        chk("e1_r_count", bus_e.r_count, 1);
        bus_e.rdn = 1'b0; step(1); bus_e.rdn = 1'b1;
        chk("e1_empty_after_pop", bus_e.r_ready, 0);
        chk("e1_d_out_zero_empty", bus_e.d_out, 0);
        send_rx(1'b1, 8'h3C, 1'b1, 1'b1, 1'b1);
        chk("e1_bad_d_out", bus_e.d_out, 8'h3C);
        chk("e1_parity_bad", bus_e.parity_error, 1);
        bus_e.rdn = 1'b0; step(1); bus_e.rdn = 1'b1;
        chk("e1_perr_zero_empty", bus_e.parity_error, 0);

        // Frame error on 8N1
        send_rx(1'b0, 8'h96, 1'b0, 1'b0, 1'b0);
        step(2);
        chk("fe_d_out", bus_n.d_out, 8'h96);
        chk("fe_frame_error", bus_n.frame_error, 1);
        chk("fe_parity_error", bus_n.parity_error, 0);
        bus_n.rdn = 1'b0; step(1); bus_n.rdn = 1'b1;
        chk("fe_ferr_zero_empty", bus_n.frame_error, 0);
        step(16);

        // False start glitch
        rx_sel  = 1'b0;
        rx_line = 1'b0;
        step(4);
        rx_line = 1'b1;
        step(30);
        chk("glitch_r_count", bus_n.r_count, 0);
        chk("glitch_r_ready", bus_n.r_ready, 0);

        // Overrun with FIFO_DEPTH=4
        for (int i = 1; i <= 5; i++) begin
            send_rx(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
            if (i == 4) begin
                chk("ovr_full_count", bus_n.r_count, 4);
                chk("ovr_not_yet", bus_n.overrun, 0);
            end
        end
        chk("ovr_r_count", bus_n.r_count, 4);
        chk("ovr_set", bus_n.overrun, 1);
        chk("ovr_head", bus_n.d_out, 8'h01);
        bus_n.rdn = 1'b0; step(1); bus_n.rdn = 1'b1;
        chk("ovr_cleared", bus_n.overrun, 0);
        chk("ovr_count3", bus_n.r_count, 3);
        chk("ovr_head2", bus_n.d_out, 8'h02);
        bus_n.rdn = 1'b0; step(2); bus_n.rdn = 1'b1;
        chk("ovr_count1", bus_n.r_count, 1);
        chk("ovr_head4", bus_n.d_out, 8'h04);
        bus_n.rdn = 1'b0; step(3); bus_n.rdn = 1'b1;
        chk("ovr_count0", bus_n.r_count, 0);
        chk("ovr_empty", bus_n.r_ready, 0);
        chk("ovr_d_out_zero", bus_n.d_out, 0);

        // Reset during TX data bit 3
        wr_n(8'hA5);
        t0 = cyc + 1;
        wait_until(t0 + 16*4 + 5);
        chk("rstmid_txd_before", txd_n, 0);
        #2 clrn = 1'b0;
        #1;
        chk("rstmid_txd", txd_n, 1);
        chk("rstmid_t_empty", bus_n.t_empty, 1);
        step(2);
        clrn = 1'b1;
        step(1);
        wr_n(8'h3C);
        t0 = cyc + 1;
        chk("rstmid_write_taken", bus_n.t_empty, 0);
        check_frame(8'h3C, t0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
